act_out_fifo: RTL and testbench
===============================

# act_out_fifo

Activation and output queue placed directly downstream of the 16-bit accumulator buffer in the VAE datapath. Each time the accumulator pulses `done`, this block takes the accumulated Q8.8 sum and adds a per-neuron bias with saturation. It then applies ReLU (or leaky ReLU, when configured) and queues the result in a small FIFO. The next layer drains the FIFO through a valid/ready handshake.

## Interface

Parameters:
- `DEPTH`, 8: FIFO entries; must be a power of two, ≥2.
- `CW`, $clog2(DEPTH+1): width of `count`.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low; clock `clk`.
- `in_valid` in 1: one-cycle strobe; connected to the accumulator's `done`.
- `in_data` in 16: accumulated sum, signed Q8.8.
- `bias` in 16: signed Q8.8 bias, sampled together with `in_data`.
- `out_valid` out 1: FIFO head is valid.
- `out_ready` in 1: consumer accepts the head this cycle.
- `out_data` out 16: activated result, signed Q8.8.
- `count` out CW: current FIFO occupancy.
- `full` out 1: `count == DEPTH`.
- `empty` out 1: `count == 0`.
- `overflow` out 1: sticky flag; set when a result is dropped.

## Operation

- **Stage 1 (act), registered.** On `in_valid`:
  - `s17 = sext(in_data) + sext(bias)`.
  - Saturate to 16 bits: if `s17 > 32767`, result is 16'h7FFF; if `s17 < -32768`, result is 16'h8000.
  - Activation: if the saturated value is negative, ReLU gives 0 (leaky variant: see Configuration). Otherwise pass it unchanged.
  - The result is registered into `act_q` and `act_v` is set; `act_v` clears on the next cycle unless `in_valid` is high again.
- **Stage 2 (FIFO write).** When `act_v` is set:
  - If the FIFO is not full, or a pop happens in the same cycle, write `act_q` at `wr_ptr` and increment `wr_ptr`.
  - Otherwise drop the result and set `overflow`.
- **Pop.** A pop happens when `out_valid && out_ready`; `rd_ptr` increments.
- **Pointers.** Both pointers are log2(DEPTH) bits and wrap naturally.
- **Count update.** `count` changes by +1 on push only, -1 on pop only, and 0 on both or neither.
- **Output.** `out_data` = `mem[rd_ptr]` (first-word fall-through); `out_valid = !empty`. `out_data` is don't-care while `out_valid` is 0.
- **Throughput.** Back-to-back `in_valid` on every cycle is accepted.
- **Overflow.** `overflow` clears only on reset.
- **Reset values.**
  - Outputs: `out_valid` 0, `count` 0, `full` 0, `empty` 1, `overflow` 0.
  - Internal: `act_v` 0, both pointers 0.
  - `mem` contents are not reset.
- **Reset mid-operation.** Any in-flight stage-1 result and all queued entries are discarded.

## Timing

- **Latency.** `in_valid` sampled at edge N puts the result in `act_q` at N. The FIFO write occurs at edge N+1. With the FIFO previously empty, `out_valid` = 1 in the cycle after edge N+1, i.e. 2 cycles from the input edge.
- **Pop.** A pop takes effect at the clock edge. The next head appears in the following cycle without a bubble.
- **Full with simultaneous push and pop.** Both are performed; `count` stays at `DEPTH`; no overflow.
- **Empty with push only.** No pop is possible (`out_valid` = 0); `count` becomes 1.
- **Flags.** `full`, `empty` and `count` are combinational from registered state and never lag by a cycle.

## Configuration

- **`LEAKY_RELU_EN` defined.** A negative saturated value v outputs `v >>> 3` (arithmetic shift, slope 1/8). Rounding is toward −inf: -1 (16'hFFFF) stays 16'hFFFF.
- **`LEAKY_RELU_EN` undefined.** Plain ReLU: negative values output 16'h0000.
- Latency and all other behaviour are identical in both builds.

## Structure

- **Shared include `vae_pkg.vh`.** Holds the Q8.8 constants `Q_FRAC=8`, `Q_W=16`, `Q_MAX=16'h7FFF`, `Q_MIN=16'h8000`, and `LEAKY_SHIFT=3`. These are reused by the multiplier and accumulator stages.
- **Sub-module `sat_act`.** Purely combinational: 16-bit `in_data` and `bias` in, 16-bit activated result out. It holds the add, saturation and activation logic. The top module contains the stage-1 register, FIFO storage, pointers and flags.

## Test plan

- **Single passthrough.** `in_data` = 16'h0180 (1.5), `bias` = 16'h0080 (0.5), one pulse → 2 cycles later `out_valid` = 1 and `out_data` = 16'h0200. Then `out_ready` = 1 → `empty` = 1.
- **Saturation and negative input.**
  - 16'h7F00 + 16'h0200 → 16'h7FFF.
  - 16'hFF00 + 16'h0000 → 16'h0000 (ReLU) or 16'hFFE0 (`LEAKY_RELU_EN`).
  - 16'h8000 + 16'h8000 → saturates to 16'h8000, then 0 (ReLU) or 16'hF000 (`LEAKY_RELU_EN`).
- **Fill and overflow.** With `out_ready` = 0, pulse 9 times with values 1..9 → `full` = 1 after the 8th write, `overflow` = 1 after the 9th. Draining returns 1..8 in order.
- **Simultaneous push/pop while full.** FIFO full, `out_ready` = 1 held, one more pulse → `count` stays 8, `overflow` stays 0, output order is preserved.
- **Back-to-back and wrap.** 20 consecutive `in_valid` pulses with `out_ready` = 1 throughout → all 20 results appear in order, pointers wrap twice, `count` ≤ 2.
- **Reset mid-operation.** Three entries queued plus one in `act_q`, assert `rst_n` = 0 for one cycle → `count` = 0, `out_valid` = 0, `overflow` = 0. The stale `act_q` entry never appears.

Source files
------------

// File: rtl/act_out_fifo_pkg.sv
// Q8.8 number-format constants shared by the VAE datapath stages.
// Consumed by the activation stage and its output queue.
package act_out_fifo_pkg;

   localparam int Q_FRAC = 8;
   localparam int Q_W = 16;
   localparam int Q_INT = Q_W - Q_FRAC;
   localparam logic [Q_W-1:0] Q_MAX = 16'h7FFF;
   localparam logic [Q_W-1:0] Q_MIN = 16'h8000;
   localparam int LEAKY_SHIFT = 3;

   typedef logic [Q_W-1:0] q_t;

   // Clamp a 17-bit signed sum back into the Q8.8 range.
   function automatic q_t q_sat(input logic [Q_W:0] s);
      q_t r;
      if (s[Q_W] != s[Q_W-1])
         r = s[Q_W] ? Q_MIN : Q_MAX;
      else
         r = s[Q_W-1:0];
      return r;
   endfunction

endpackage

// File: rtl/act_out_fifo_sat_act.sv
// Bias add with saturation followed by ReLU / leaky ReLU.
// Leaky slope enabled by LEAKY_RELU_EN.
module sat_act
   import act_out_fifo_pkg::*;
(
   input  logic [15:0] in_data,
   input  logic [15:0] bias,
   output logic [15:0] act_data
);

   logic [16:0] s17;
   q_t          sat;

   assign s17 = {in_data[15], in_data} + {bias[15], bias};
   assign sat = q_sat(s17);

   always_comb begin
      act_data = sat;
      if (sat[Q_W-1]) begin
`ifdef LEAKY_RELU_EN
         act_data = q_t'($signed(sat) >>> LEAKY_SHIFT);
`else
         act_data = '0;
`endif
      end
   end

endmodule

// File: rtl/act_out_fifo.sv
// Activation stage plus first-word fall-through output queue.
// Optional leaky activation selected with LEAKY_RELU_EN.
module act_out_fifo
   import act_out_fifo_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [15:0]   in_data,
   input  logic [15:0]   bias,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [15:0]   out_data,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty,
   output logic          overflow
);

   localparam int AW = $clog2(DEPTH);

   q_t          act_d;
   q_t          act_q;
   logic        act_v;
   q_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic        push;
   logic        pop;

   sat_act u_sat_act (
      .in_data  (in_data),
      .bias     (bias),
      .act_data (act_d)
   );

   assign count     = cnt;
   assign full      = (cnt == CW'(DEPTH));
   assign empty     = (cnt == '0);
   assign out_valid = !empty;
   assign out_data  = mem[rd_ptr];
   assign pop       = out_valid && out_ready;
   // A pop frees the slot this cycle, so a full queue still accepts.
   assign push      = act_v && (!full || pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         act_v <= 1'b0;
         act_q <= '0;
      end else begin
         act_v <= in_valid;
         if (in_valid)
            act_q <= act_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= act_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         unique case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
         if (act_v && !push)
            overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_act_out_fifo.sv
// Directed bench for act_out_fifo with an output scoreboard.
// Expected activations follow LEAKY_RELU_EN when it is defined.
module tb_act_out_fifo;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] in_data;
   logic [15:0] bias;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [3:0]  count;
   logic        full;
   logic        empty;
   logic        overflow;

   int checks = 0;
   int errors = 0;
   logic [15:0] sb[$];

   act_out_fifo #(.DEPTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .bias      (bias),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every accepted head is compared with the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected", {16'h0, out_data}, 32'hDEAD);
         end else begin
            chk("sb_data", {16'h0, out_data}, {16'h0, sb.pop_front()});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [15:0] d, input logic [15:0] b);
      in_valid = 1'b1;
      in_data  = d;
      bias     = b;
      step();
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic drain();
      int n;
      out_ready = 1'b1;
      n = 0;
      while (!empty && n < 100) begin
         step();
         n++;
      end
      step();
      chk("drain_empty", {31'h0, empty}, 32'h1);
      chk("drain_sb", sb.size(), 32'h0);
   endtask

   initial begin
      int maxc;
      logic [15:0] e_neg1;
      logic [15:0] e_min;
`ifdef LEAKY_RELU_EN
      e_neg1 = 16'hFFE0;
      e_min  = 16'hF000;
`else
      e_neg1 = 16'h0000;
      e_min  = 16'h0000;
`endif
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      bias      = '0;
      out_ready = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_count", {28'h0, count}, 32'h0);
      chk("rst_full", {31'h0, full}, 32'h0);
      chk("rst_empty", {31'h0, empty}, 32'h1);
      chk("rst_overflow", {31'h0, overflow}, 32'h0);

      // single passthrough, latency 2
      sb.push_back(16'h0200);
      pulse(16'h0180, 16'h0080);
      chk("lat_n_valid", {31'h0, out_valid}, 32'h0);
      step();
      chk("lat_n1_valid", {31'h0, out_valid}, 32'h1);
      chk("pass_data", {16'h0, out_data}, 32'h0200);
      chk("pass_count", {28'h0, count}, 32'h1);
      out_ready = 1'b1;
      step();
      chk("pass_empty", {31'h0, empty}, 32'h1);

      // saturation and negative inputs
      sb.push_back(16'h7FFF);
      pulse(16'h7F00, 16'h0200);
      sb.push_back(e_neg1);
      pulse(16'hFF00, 16'h0000);
      sb.push_back(e_min);
      pulse(16'h8000, 16'h8000);
      drain();

      // fill and overflow
      out_ready = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         sb.push_back(16'(i));
         pulse(16'(i), 16'h0);
      end
      step();
      chk("fill_full", {31'h0, full}, 32'h1);
      chk("fill_count", {28'h0, count}, 32'h8);
      chk("fill_no_ovf", {31'h0, overflow}, 32'h0);
      pulse(16'd9, 16'h0);
      step();
      chk("ovf_set", {31'h0, overflow}, 32'h1);
      chk("ovf_count", {28'h0, count}, 32'h8);
      drain();
      chk("ovf_sticky", {31'h0, overflow}, 32'h1);
      do_reset();
      chk("ovf_cleared", {31'h0, overflow}, 32'h0);

      // push and pop together while full
      out_ready = 1'b0;
      for (int i = 10; i <= 17; i++) begin
         sb.push_back(16'(i));
         pulse(16'(i), 16'h0);
      end
      step();
      chk("pp_full", {31'h0, full}, 32'h1);
      sb.push_back(16'd18);
      pulse(16'd18, 16'h0);
      out_ready = 1'b1;
      step();
      chk("pp_count", {28'h0, count}, 32'h8);
      chk("pp_no_ovf", {31'h0, overflow}, 32'h0);
      drain();
      chk("pp_ovf_after", {31'h0, overflow}, 32'h0);

      // back-to-back with wrap
      out_ready = 1'b1;
      maxc = 0;
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         in_data  = 16'(100 + 3 * i);
         bias     = 16'(i);
         sb.push_back(16'(100 + 4 * i));
         step();
         if (int'(count) > maxc)
            maxc = int'(count);
      end
      in_valid = 1'b0;
      drain();
      chk("b2b_max_count", (maxc <= 2) ? 32'h1 : 32'h0, 32'h1);

      // reset mid-operation
      out_ready = 1'b0;
      pulse(16'h0011, 16'h0);
      pulse(16'h0022, 16'h0);
      pulse(16'h0033, 16'h0);
      in_valid = 1'b1;
      in_data  = 16'h0044;
      step();
      in_valid = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("mid_count", {28'h0, count}, 32'h0);
      chk("mid_valid", {31'h0, out_valid}, 32'h0);
      chk("mid_overflow", {31'h0, overflow}, 32'h0);
      out_ready = 1'b1;
      step();
      step();
      step();
      chk("mid_stale", {31'h0, out_valid}, 32'h0);
      chk("mid_sb", sb.size(), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
